// File: rtl/ppl_frame_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ppl_pkg
// Shared definitions for the ray-cast pipeline frame controller: the frame
// state encoding and the bus widths of pixels, block-map entries, position
// and view-angle values.
// ---------------------------------------------------------------------------
package ppl_pkg;

    localparam int PIX_W      = 20;
    localparam int BLK_ADDR_W = 15;
    localparam int BLK_ID_W   = 4;
    localparam int POS_W      = 16;
    localparam int ANG_W      = 20;

    // Frame scheduler states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } frame_state_t;

endpackage

// File: rtl/ppl_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// ppl_frame_ctrl_if
// Bundles every non-clock signal of the frame controller.
//   slave  : the controller side (pose/edit/frame inputs, snapshot and
//            block-map write outputs, status flags)
//   master : the game-logic / display / pipeline side
// ---------------------------------------------------------------------------
interface ppl_frame_ctrl_if;
    import ppl_pkg::*;

    logic                           frame_req;
    logic        [POS_W-1:0]        pos_x_in;
    logic        [POS_W-1:0]        pos_y_in;
    logic        [POS_W-1:0]        pos_z_in;
    logic signed [ANG_W-1:0]        ang_x_in;
    logic signed [ANG_W-1:0]        ang_y_in;
    logic                           ppl_valid;
    logic                           edit_req;
    logic        [BLK_ADDR_W-1:0]   edit_addr;
    logic        [BLK_ID_W-1:0]     edit_id;

    logic        [POS_W-1:0]        p_pos_x;
    logic        [POS_W-1:0]        p_pos_y;
    logic        [POS_W-1:0]        p_pos_z;
    logic signed [ANG_W-1:0]        p_angle_x;
    logic signed [ANG_W-1:0]        p_angle_y;
    logic                           ppl_rst;
    logic                           map_we;
    logic        [BLK_ADDR_W-1:0]   map_addr;
    logic        [BLK_ID_W-1:0]     map_wdata;
    logic                           edit_ack;
    logic                           frame_busy;
    logic                           frame_done;
    logic        [PIX_W-1:0]        pix_cnt;
    logic                           overrun;
    logic                           wdog_err;

    modport slave (
        input  frame_req, pos_x_in, pos_y_in, pos_z_in, ang_x_in, ang_y_in,
               ppl_valid, edit_req, edit_addr, edit_id,
        output p_pos_x, p_pos_y, p_pos_z, p_angle_x, p_angle_y, ppl_rst,
               map_we, map_addr, map_wdata, edit_ack, frame_busy, frame_done,
               pix_cnt, overrun, wdog_err
    );

    modport master (
        output frame_req, pos_x_in, pos_y_in, pos_z_in, ang_x_in, ang_y_in,
               ppl_valid, edit_req, edit_addr, edit_id,
        input  p_pos_x, p_pos_y, p_pos_z, p_angle_x, p_angle_y, ppl_rst,
               map_we, map_addr, map_wdata, edit_ack, frame_busy, frame_done,
               pix_cnt, overrun, wdog_err
    );

endinterface

// File: rtl/ppl_frame_ctrl_pose_latch.sv
// ---------------------------------------------------------------------------
// ppl_pose_latch
// Five snapshot registers holding the player pose for one frame.
//   clk, rst        : pipeline clock, async active-high reset (clears to 0)
//   i_load          : capture all five inputs on this clock edge
//   i_pos_*/i_ang_* : live pose
//   o_pos_*/o_ang_* : frozen pose
// ---------------------------------------------------------------------------
module ppl_pose_latch
    import ppl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_load,
    input  logic        [POS_W-1:0] i_pos_x,
    input  logic        [POS_W-1:0] i_pos_y,
    input  logic        [POS_W-1:0] i_pos_z,
    input  logic signed [ANG_W-1:0] i_ang_x,
    input  logic signed [ANG_W-1:0] i_ang_y,
    output logic        [POS_W-1:0] o_pos_x,
    output logic        [POS_W-1:0] o_pos_y,
    output logic        [POS_W-1:0] o_pos_z,
    output logic signed [ANG_W-1:0] o_ang_x,
    output logic signed [ANG_W-1:0] o_ang_y
);

    // Pose only moves when the controller opens the load window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_pos_x <= '0;
            o_pos_y <= '0;
            o_pos_z <= '0;
            o_ang_x <= '0;
            o_ang_y <= '0;
        end else if (i_load) begin
            o_pos_x <= i_pos_x;
            o_pos_y <= i_pos_y;
            o_pos_z <= i_pos_z;
            o_ang_x <= i_ang_x;
            o_ang_y <= i_ang_y;
        end
    end

endmodule

// File: rtl/ppl_frame_ctrl.sv
// ---------------------------------------------------------------------------
// ppl_frame_ctrl
// Frame-level scheduler for the ray-cast pipeline. Freezes the player pose
// once per frame, releases the pipeline for exactly H_DISP*V_DISP retired
// pixels plus a drain period, and grants block-map edits only while idle.
//   clk_ppl : pipeline clock
//   rst     : async active-high reset
//   bus     : ppl_frame_ctrl_if.slave (frame/pose/edit inputs, snapshot,
//             block-map write port, status flags)
// Optional feature: define PPL_FRAME_WDOG_EN to build the RUN watchdog
// (adds parameter WDOG_CYC); otherwise wdog_err is tied low.
// ---------------------------------------------------------------------------
module ppl_frame_ctrl
    import ppl_pkg::*;
#(
    parameter int H_DISP    = 1280,
    parameter int V_DISP    = 720,
    parameter int DRAIN_CYC = 16
`ifdef PPL_FRAME_WDOG_EN
    ,
    parameter int WDOG_CYC  = 4096
`endif
) (
    input  logic            clk_ppl,
    input  logic            rst,
    ppl_frame_ctrl_if.slave bus
);

    localparam logic [PIX_W-1:0] PIX_LAST   = PIX_W'(H_DISP * V_DISP - 1);
    localparam logic [7:0]       DRAIN_LAST = 8'(DRAIN_CYC - 1);
`ifdef PPL_FRAME_WDOG_EN
    localparam logic [15:0]      WDOG_LAST  = 16'(WDOG_CYC - 1);
    logic [15:0]                 r_wdogCnt;
    logic                        r_wdogErr;
`endif

    frame_state_t           r_state;
    logic                   r_pending;
    logic                   r_overrun;
    logic                   r_pplRst;
    logic                   r_frameBusy;
    logic                   r_frameDone;
    logic                   r_mapWe;
    logic [BLK_ADDR_W-1:0]  r_mapAddr;
    logic [BLK_ID_W-1:0]    r_mapWdata;
    logic [PIX_W-1:0]       r_pixCnt;
    logic [7:0]             r_drainCnt;
    logic                   w_load;

    assign w_load = (r_state == ST_LATCH);

    ppl_pose_latch u_pose (
        .clk     (clk_ppl),
        .rst     (rst),
        .i_load  (w_load),
        .i_pos_x (bus.pos_x_in),
        .i_pos_y (bus.pos_y_in),
        .i_pos_z (bus.pos_z_in),
        .i_ang_x (bus.ang_x_in),
        .i_ang_y (bus.ang_y_in),
        .o_pos_x (bus.p_pos_x),
        .o_pos_y (bus.p_pos_y),
        .o_pos_z (bus.p_pos_z),
        .o_ang_x (bus.p_angle_x),
        .o_ang_y (bus.p_angle_y)
    );

    // Frame FSM with all status outputs registered alongside the state.
    // frame_busy is tracked as its own register so it changes on exactly the
    // edges that enter/leave IDLE. map_we doubles as the "just acked" marker
    // that blocks a back-to-back grant.
    always_ff @(posedge clk_ppl or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pending   <= 1'b0;
            r_overrun   <= 1'b0;
            r_pplRst    <= 1'b1;
            r_frameBusy <= 1'b0;
            r_frameDone <= 1'b0;
            r_mapWe     <= 1'b0;
            r_mapAddr   <= '0;
            r_mapWdata  <= '0;
            r_pixCnt    <= '0;
            r_drainCnt  <= '0;
`ifdef PPL_FRAME_WDOG_EN
            r_wdogCnt   <= '0;
            r_wdogErr   <= 1'b0;
`endif
        end else begin
            r_mapWe     <= 1'b0;
            r_frameDone <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.edit_req && !r_mapWe) begin
                        r_mapWe    <= 1'b1;
                        r_mapAddr  <= bus.edit_addr;
                        r_mapWdata <= bus.edit_id;
                    end
                    if (bus.frame_req || r_pending) begin
                        r_state     <= ST_LATCH;
                        r_pending   <= 1'b0;
                        r_frameBusy <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    r_pixCnt <= '0;
                    r_pplRst <= 1'b0;
                    r_state  <= ST_RUN;
`ifdef PPL_FRAME_WDOG_EN
                    r_wdogCnt <= '0;
`endif
                end
                ST_RUN: begin
                    // The final pixel does not increment, so the count tops
                    // out at the last pixel index and never wraps.
                    if (bus.ppl_valid) begin
                        if (r_pixCnt == PIX_LAST) begin
                            r_state    <= ST_DRAIN;
                            r_drainCnt <= '0;
                        end else begin
                            r_pixCnt <= r_pixCnt + 1'b1;
                        end
`ifdef PPL_FRAME_WDOG_EN
                        r_wdogCnt <= '0;
                    end else if (r_wdogCnt == WDOG_LAST) begin
                        r_state     <= ST_IDLE;
                        r_pplRst    <= 1'b1;
                        r_frameBusy <= 1'b0;
                        r_frameDone <= 1'b1;
                        r_wdogErr   <= 1'b1;
                    end else begin
                        r_wdogCnt <= r_wdogCnt + 1'b1;
`endif
                    end
                end
                ST_DRAIN: begin
                    if (r_drainCnt == DRAIN_LAST) begin
                        r_state     <= ST_IDLE;
                        r_pplRst    <= 1'b1;
                        r_frameBusy <= 1'b0;
                        r_frameDone <= 1'b1;
                    end else begin
                        r_drainCnt <= r_drainCnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            // Requests while busy collapse into one pending frame
            if ((r_state != ST_IDLE) && bus.frame_req) begin
                r_pending <= 1'b1;
                r_overrun <= 1'b1;
            end
        end
    end

    assign bus.ppl_rst    = r_pplRst;
    assign bus.map_we     = r_mapWe;
    assign bus.edit_ack   = r_mapWe;
    assign bus.map_addr   = r_mapAddr;
    assign bus.map_wdata  = r_mapWdata;
    assign bus.frame_busy = r_frameBusy;
    assign bus.frame_done = r_frameDone;
    assign bus.pix_cnt    = r_pixCnt;
    assign bus.overrun    = r_overrun;
`ifdef PPL_FRAME_WDOG_EN
    assign bus.wdog_err   = r_wdogErr;
`else
    assign bus.wdog_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ppl_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ppl_frame_ctrl
// Self-checking bench for ppl_frame_ctrl with a 4x2 frame and a 2-cycle
// drain. A vector table covers one full frame; hand-written sequences cover
// edits, overrun, reset mid-frame and (with PPL_FRAME_WDOG_EN) the watchdog.
// ---------------------------------------------------------------------------
module tb_ppl_frame_ctrl;

    logic clk_ppl;
    logic rst;
    int   errCount;
    int   checkCount;

    ppl_frame_ctrl_if bus();

    ppl_frame_ctrl #(
        .H_DISP    (4),
        .V_DISP    (2),
        .DRAIN_CYC (2)
`ifdef PPL_FRAME_WDOG_EN
        ,
        .WDOG_CYC  (32)
`endif
    ) dut (
        .clk_ppl (clk_ppl),
        .rst     (rst),
        .bus     (bus)
    );

    // Free-running pipeline clock
    initial begin
        clk_ppl = 1'b0;
        forever #5 clk_ppl = ~clk_ppl;
    end

    typedef struct {
        logic        frameReq;
        logic        pplValid;
        logic [15:0] posX;
        logic        expPplRst;
        logic        expBusy;
        logic [19:0] expPix;
        logic        expDone;
        logic [15:0] expPosX;
    } vec_t;

    vec_t vecs[13];

    // Inputs and samples both move 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk_ppl);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.frame_req = v.frameReq;
        bus.ppl_valid = v.pplValid;
        bus.pos_x_in  = v.posX;
        tick();
    endtask

    task automatic startFrame();
        bus.frame_req = 1'b1;
        tick();
        bus.frame_req = 1'b0;
        tick();
    endtask

    task automatic runPixels(input int n);
        bus.ppl_valid = 1'b1;
        for (int i = 0; i < n; i++) tick();
        bus.ppl_valid = 1'b0;
    endtask

    // Bounded wait for the frame_done pulse; a timeout counts as a failure
    task automatic waitDone(input string name, output int weSeen);
        bit found;
        found  = 1'b0;
        weSeen = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (bus.frame_done) found = 1'b1;
            else weSeen += int'(bus.map_we);
        end
        checkOutput(name, 32'(found), 32'd1);
    endtask

    initial begin
        int weSeen;
        int busyCnt;
        errCount      = 0;
        checkCount    = 0;
        rst           = 1'b1;
        bus.frame_req = 1'b0;
        bus.ppl_valid = 1'b0;
        bus.edit_req  = 1'b0;
        bus.edit_addr = '0;
        bus.edit_id   = '0;
        bus.pos_x_in  = 16'h0100;
        bus.pos_y_in  = 16'h0011;
        bus.pos_z_in  = 16'h0022;
        bus.ang_x_in  = -20'sd5;
        bus.ang_y_in  = 20'sd1234;

        //              fr    val   posX      rst  busy pix    done posX
        vecs[0]  = '{1'b1, 1'b0, 16'h0100, 1'b1, 1'b1, 20'd0, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 1'b0, 16'h0100, 1'b0, 1'b1, 20'd0, 1'b0, 16'h0100};
        vecs[2]  = '{1'b0, 1'b1, 16'h0100, 1'b0, 1'b1, 20'd1, 1'b0, 16'h0100};
        vecs[3]  = '{1'b0, 1'b1, 16'h0100, 1'b0, 1'b1, 20'd2, 1'b0, 16'h0100};
        vecs[4]  = '{1'b0, 1'b1, 16'h0200, 1'b0, 1'b1, 20'd3, 1'b0, 16'h0100};
        vecs[5]  = '{1'b0, 1'b1, 16'h0200, 1'b0, 1'b1, 20'd4, 1'b0, 16'h0100};
        vecs[6]  = '{1'b0, 1'b1, 16'h0200, 1'b0, 1'b1, 20'd5, 1'b0, 16'h0100};
        vecs[7]  = '{1'b0, 1'b1, 16'h0200, 1'b0, 1'b1, 20'd6, 1'b0, 16'h0100};
        vecs[8]  = '{1'b0, 1'b1, 16'h0200, 1'b0, 1'b1, 20'd7, 1'b0, 16'h0100};
        vecs[9]  = '{1'b0, 1'b1, 16'h0200, 1'b0, 1'b1, 20'd7, 1'b0, 16'h0100};
        vecs[10] = '{1'b0, 1'b0, 16'h0200, 1'b0, 1'b1, 20'd7, 1'b0, 16'h0100};
        vecs[11] = '{1'b0, 1'b0, 16'h0200, 1'b1, 1'b0, 20'd7, 1'b1, 16'h0100};
        vecs[12] = '{1'b0, 1'b0, 16'h0200, 1'b1, 1'b0, 20'd7, 1'b0, 16'h0100};

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("reset ppl_rst",  32'(bus.ppl_rst),    32'd1);
        checkOutput("reset busy",     32'(bus.frame_busy), 32'd0);
        checkOutput("reset pix_cnt",  32'(bus.pix_cnt),    32'd0);
        checkOutput("reset map_we",   32'(bus.map_we),     32'd0);
        checkOutput("reset edit_ack", 32'(bus.edit_ack),   32'd0);
        checkOutput("reset done",     32'(bus.frame_done), 32'd0);
        checkOutput("reset overrun",  32'(bus.overrun),    32'd0);
        checkOutput("reset wdog_err", 32'(bus.wdog_err),   32'd0);
        checkOutput("reset p_pos_x",  32'(bus.p_pos_x),    32'd0);

        // One full frame driven from the table
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("row%0d ppl_rst", i), 32'(bus.ppl_rst),    32'(vecs[i].expPplRst));
            checkOutput($sformatf("row%0d busy", i),    32'(bus.frame_busy), 32'(vecs[i].expBusy));
            checkOutput($sformatf("row%0d pix_cnt", i), 32'(bus.pix_cnt),    32'(vecs[i].expPix));
            checkOutput($sformatf("row%0d done", i),    32'(bus.frame_done), 32'(vecs[i].expDone));
            checkOutput($sformatf("row%0d p_pos_x", i), 32'(bus.p_pos_x),    32'(vecs[i].expPosX));
        end
        checkOutput("snapshot p_pos_y",   32'(bus.p_pos_y),   32'h0011);
        checkOutput("snapshot p_angle_x", 32'(bus.p_angle_x), 32'hFFFF_FFFB);
        checkOutput("snapshot p_angle_y", 32'(bus.p_angle_y), 32'd1234);

        // Edit requested during RUN waits for IDLE
        startFrame();
        checkOutput("new latch p_pos_x", 32'(bus.p_pos_x), 32'h0200);
        bus.edit_req  = 1'b1;
        bus.edit_addr = 15'h1234;
        bus.edit_id   = 4'd5;
        runPixels(8);
        waitDone("edit frame done", weSeen);
        checkOutput("no write while busy", 32'(weSeen), 32'd0);
        tick();
        checkOutput("edit map_we",     32'(bus.map_we),    32'd1);
        checkOutput("edit edit_ack",   32'(bus.edit_ack),  32'd1);
        checkOutput("edit map_addr",   32'(bus.map_addr),  32'h1234);
        checkOutput("edit map_wdata",  32'(bus.map_wdata), 32'd5);
        tick();
        checkOutput("edit gap cycle",  32'(bus.map_we),    32'd0);
        bus.edit_req = 1'b0;
        tick();
        checkOutput("edit dropped",    32'(bus.map_we),    32'd0);

        // Frame and edit in the same IDLE cycle
        bus.frame_req = 1'b1;
        bus.edit_req  = 1'b1;
        bus.edit_addr = 15'h0055;
        bus.edit_id   = 4'hA;
        tick();
        bus.frame_req = 1'b0;
        bus.edit_req  = 1'b0;
        checkOutput("same map_we",    32'(bus.map_we),     32'd1);
        checkOutput("same edit_ack",  32'(bus.edit_ack),   32'd1);
        checkOutput("same map_addr",  32'(bus.map_addr),   32'h0055);
        checkOutput("same map_wdata", 32'(bus.map_wdata),  32'hA);
        checkOutput("same latch busy", 32'(bus.frame_busy), 32'd1);
        tick();
        checkOutput("same run ppl_rst", 32'(bus.ppl_rst),  32'd0);
        checkOutput("same run map_we",  32'(bus.map_we),   32'd0);
        runPixels(8);
        waitDone("same frame done", weSeen);
        checkOutput("same pix_cnt", 32'(bus.pix_cnt), 32'd7);

        // Two requests during RUN collapse into one extra frame
        tick();
        startFrame();
        bus.ppl_valid = 1'b1;
        tick();
        tick();
        bus.frame_req = 1'b1;
        tick();
        bus.frame_req = 1'b0;
        checkOutput("overrun set", 32'(bus.overrun), 32'd1);
        tick();
        bus.frame_req = 1'b1;
        tick();
        bus.frame_req = 1'b0;
        runPixels(3);
        waitDone("overrun frame done", weSeen);
        tick();
        checkOutput("pending frame latch", 32'(bus.frame_busy), 32'd1);
        tick();
        runPixels(8);
        waitDone("pending frame done", weSeen);
        busyCnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            busyCnt += int'(bus.frame_busy);
        end
        checkOutput("only one extra frame", 32'(busyCnt),     32'd0);
        checkOutput("overrun sticky",       32'(bus.overrun), 32'd1);

`ifdef PPL_FRAME_WDOG_EN
        // Pixel stream stops mid-frame: watchdog aborts after 32 quiet cycles
        startFrame();
        runPixels(3);
        busyCnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            busyCnt++;
            if (bus.frame_done) break;
        end
        checkOutput("wdog abort cycles", 32'(busyCnt),       32'd32);
        checkOutput("wdog_err set",      32'(bus.wdog_err),  32'd1);
        checkOutput("wdog busy",         32'(bus.frame_busy), 32'd0);
        checkOutput("wdog ppl_rst",      32'(bus.ppl_rst),   32'd1);
        tick();
        checkOutput("wdog single done",  32'(bus.frame_done), 32'd0);
`else
        checkOutput("wdog_err tied low", 32'(bus.wdog_err), 32'd0);
`endif

        // Asynchronous reset mid-frame discards everything
        bus.edit_req  = 1'b1;
        startFrame();
        runPixels(3);
        rst = 1'b1;
        #1;
        checkOutput("midrst ppl_rst", 32'(bus.ppl_rst),    32'd1);
        checkOutput("midrst busy",    32'(bus.frame_busy), 32'd0);
        checkOutput("midrst pix_cnt", 32'(bus.pix_cnt),    32'd0);
        checkOutput("midrst overrun", 32'(bus.overrun),    32'd0);
        checkOutput("midrst p_pos_x", 32'(bus.p_pos_x),    32'd0);
        bus.edit_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        checkOutput("midrst idle busy", 32'(bus.frame_busy), 32'd0);
        checkOutput("midrst no write",  32'(bus.map_we),     32'd0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
